// File: rtl/digit_chaser_pkg.sv
// Shared definitions for the digit chaser: FSM state encoding and
// direction constants used by the top level and the bench.
package digit_chaser_pkg;

    // Chaser FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } chase_state_t;

    // Direction encoding shared by the dir input and the bounce direction
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage : digit_chaser_pkg

// File: rtl/digit_chaser_onehot_decoder.sv
// Binary index to one-hot select decoder with an enable; all zero when
// disabled. Indices beyond NUM_DIGITS-1 decode to all zero.
module onehot_decoder #(
    parameter int NUM_DIGITS = 4,
    parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic [IDX_W-1:0]      sel,
    input  logic                  en,
    output logic [NUM_DIGITS-1:0] onehot
);

    // Compare the index against every position so no out-of-range write occurs
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            onehot[i] = en && (sel == IDX_W'(i));
        end
    end

endmodule : onehot_decoder

// File: rtl/digit_chaser.sv
// One-hot position sequencer for the display select lines. A single lit
// position walks across NUM_DIGITS positions while run is held, in
// circular or ping-pong mode, with pause, an end-of-sweep pulse and a
// saturating sweep counter.
//
// Handshake: there is none; run/hold/dir/bounce are level controls sampled
// on every rising clk5Hz edge, and every output is either a register or a
// decode of registered state, so no input reaches an output combinationally.
module digit_chaser
    import digit_chaser_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CNT_W      = 8,
    parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic                  clk5Hz,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic                  hold,
    input  logic                  dir,
    input  logic                  bounce,
    output logic [NUM_DIGITS-1:0] z,
    output logic [IDX_W-1:0]      idx,
    output logic                  active,
    output logic                  wrap,
    output logic [CNT_W-1:0]      sweeps
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DIGITS - 1);

    chase_state_t     state;
    chase_state_t     state_nxt;
    logic             bdir;

    // Candidate result of one step from the current position
    logic             eff_dir;
    logic [IDX_W-1:0] step_idx;
    logic             step_wrap;
    logic             step_bdir;

    // State register
    always_ff @(posedge clk5Hz) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: run=0 beats hold, hold beats stepping
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (run) state_nxt = ST_RUN;
            end
            ST_RUN, ST_PAUSE: begin
                if (!run)      state_nxt = ST_IDLE;
                else if (hold) state_nxt = ST_PAUSE;
                else           state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from the registered state only
    always_comb begin
        active = (state != ST_IDLE);
    end

    // Step arithmetic: circular follows dir directly, bounce follows bdir and
    // turns around at the ends (an outward-pointing bdir at an end, possible
    // right after switching into bounce, is turned inward first)
    always_comb begin
        eff_dir   = bdir;
        step_idx  = idx;
        step_wrap = 1'b0;
        step_bdir = bdir;
        if (!bounce) begin
            if (dir == DIR_UP) begin
                step_wrap = (idx == LAST);
                step_idx  = step_wrap ? '0 : idx + 1'b1;
            end else begin
                step_wrap = (idx == '0);
                step_idx  = step_wrap ? LAST : idx - 1'b1;
            end
            step_bdir = dir;
        end else begin
            if (idx == LAST && bdir == DIR_UP)
                eff_dir = DIR_DN;
            else if (idx == '0 && bdir == DIR_DN)
                eff_dir = DIR_UP;
            step_idx  = (eff_dir == DIR_UP) ? idx + 1'b1 : idx - 1'b1;
            step_wrap = (step_idx == '0) || (step_idx == LAST);
            step_bdir = step_wrap ? ~eff_dir : eff_dir;
        end
    end

    // Position, bounce direction, wrap pulse and saturating sweep counter
    always_ff @(posedge clk5Hz) begin
        if (!reset_n) begin
            idx    <= '0;
            bdir   <= DIR_UP;
            wrap   <= 1'b0;
            sweeps <= '0;
        end else begin
            wrap <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        idx  <= (dir == DIR_DN) ? LAST : '0;
                        bdir <= dir;
                    end else begin
                        idx <= '0;
                    end
                end
                default: begin
                    if (!run) begin
                        idx <= '0;
                    end else if (!hold) begin
                        idx  <= step_idx;
                        bdir <= step_bdir;
                        wrap <= step_wrap;
                        if (step_wrap && sweeps != {CNT_W{1'b1}})
                            sweeps <= sweeps + 1'b1;
                    end
                end
            endcase
            // Outside bounce mode bdir shadows dir so bounce starts the right way
            if (!bounce) bdir <= dir;
        end
    end

    onehot_decoder #(
        .NUM_DIGITS (NUM_DIGITS),
        .IDX_W      (IDX_W)
    ) u_decoder (
        .sel    (idx),
        .en     (active),
        .onehot (z)
    );

endmodule : digit_chaser

// File: tb/tb_digit_chaser.sv
// Self-checking bench for digit_chaser: a reference model predicts each
// cycle's outputs, the prediction is queued when the inputs are driven and
// compared against the DUT one edge later. A second instance with a 2-bit
// counter shares the stimulus to exercise sweep saturation.
module tb_digit_chaser;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int EW = N + IW + 1 + 1 + 8 + 2;

  logic          clk5Hz;
  logic          reset_n;
  logic          run;
  logic          hold;
  logic          dir;
  logic          bounce;

  logic [N-1:0]  z;
  logic [IW-1:0] idx;
  logic          active;
  logic          wrap;
  logic [7:0]    sweeps;

  logic [N-1:0]  z_s;
  logic [IW-1:0] idx_s;
  logic          active_s;
  logic          wrap_s;
  logic [1:0]    sweeps_s;

  int n_cmp = 0;
  int n_err = 0;

  logic [EW-1:0] exp_q[$];

  // model state
  int   m_state;
  int   m_idx;
  logic m_bdir;
  logic m_wrap;
  int   m_sw8;
  int   m_sw2;

  digit_chaser #(.NUM_DIGITS(N), .CNT_W(8)) dut (
    .clk5Hz(clk5Hz), .reset_n(reset_n), .run(run), .hold(hold),
    .dir(dir), .bounce(bounce), .z(z), .idx(idx), .active(active),
    .wrap(wrap), .sweeps(sweeps)
  );

  digit_chaser #(.NUM_DIGITS(N), .CNT_W(2)) dut_s (
    .clk5Hz(clk5Hz), .reset_n(reset_n), .run(run), .hold(hold),
    .dir(dir), .bounce(bounce), .z(z_s), .idx(idx_s), .active(active_s),
    .wrap(wrap_s), .sweeps(sweeps_s)
  );

  // clock / reset block
  initial begin
    clk5Hz = 1'b0;
    forever #5 clk5Hz = ~clk5Hz;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: one rising edge with the given inputs
  task automatic model_edge(input logic r, input logic ru, input logic h,
                            input logic d, input logic b);
    logic w;
    logic nd;
    w = 1'b0;
    if (!r) begin
      m_state = 0; m_idx = 0; m_bdir = 1'b0; m_sw8 = 0; m_sw2 = 0;
    end else begin
      if (m_state == 0) begin
        if (ru) begin
          m_state = 1;
          m_idx   = d ? N - 1 : 0;
          m_bdir  = d;
        end
      end else if (!ru) begin
        m_state = 0;
        m_idx   = 0;
      end else if (h) begin
        m_state = 2;
      end else begin
        m_state = 1;
        if (!b) begin
          if (!d) begin
            m_idx = (m_idx + 1) % N;
            w = (m_idx == 0);
          end else begin
            m_idx = (m_idx + N - 1) % N;
            w = (m_idx == N - 1);
          end
        end else begin
          nd = m_bdir;
          if (m_idx == N - 1) nd = 1'b1;
          else if (m_idx == 0) nd = 1'b0;
          m_idx = nd ? m_idx - 1 : m_idx + 1;
          if (m_idx == 0 || m_idx == N - 1) begin
            w  = 1'b1;
            nd = ~nd;
          end
          m_bdir = nd;
        end
        if (w) begin
          if (m_sw8 < 255) m_sw8++;
          if (m_sw2 < 3)   m_sw2++;
        end
      end
      if (!b) m_bdir = d;
    end
    m_wrap = w;
  endtask

  function automatic logic [EW-1:0] model_pack();
    logic [N-1:0] ez;
    ez = '0;
    if (m_state != 0) ez[m_idx] = 1'b1;
    return {ez, IW'(m_idx), (m_state != 0), m_wrap, 8'(m_sw8), 2'(m_sw2)};
  endfunction

  // scoreboard: pop one prediction and compare both instances
  task automatic compare_out();
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      check_val("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val("z",        z,        e[EW-1 -: N]);
      check_val("idx",      idx,      e[EW-N-1 -: IW]);
      check_val("active",   active,   e[11]);
      check_val("wrap",     wrap,     e[10]);
      check_val("sweeps",   sweeps,   e[9:2]);
      check_val("z_s",      z_s,      e[EW-1 -: N]);
      check_val("wrap_s",   wrap_s,   e[10]);
      check_val("sweeps_s", sweeps_s, e[1:0]);
    end
  endtask

  // driver: apply inputs, predict, clock, compare
  task automatic drive(input logic r, input logic ru, input logic h,
                       input logic d, input logic b);
    reset_n = r; run = ru; hold = h; dir = d; bounce = b;
    model_edge(r, ru, h, d, b);
    exp_q.push_back(model_pack());
    @(posedge clk5Hz);
    #1;
    compare_out();
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; hold = 1'b0; dir = 1'b0; bounce = 1'b0;
    m_state = 0; m_idx = 0; m_bdir = 1'b0; m_wrap = 1'b0; m_sw8 = 0; m_sw2 = 0;
    @(negedge clk5Hz);

    // reset state
    do_reset();
    check_val("rst_z", z, 32'd0);
    check_val("rst_active", active, 32'd0);

    // circular up: 0001,0010,0100,1000,0001 with wrap on the last
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("up_final_z", z, 32'b0001);
    check_val("up_wrap", wrap, 32'd1);
    check_val("up_sweeps", sweeps, 32'd1);

    // bounce starting down: 3,2,1,0,1,2,3,2,1
    do_reset();
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check_val("bounce_idx", idx, 32'd1);
    check_val("bounce_sweeps", sweeps, 32'd2);

    // hold at idx 2 for three edges, release, then run=0 while holding
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check_val("hold_idx", idx, 32'd2);
      check_val("hold_active", active, 32'd1);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("release_idx", idx, 32'd3);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("stop_in_hold_z", z, 32'd0);

    // five circular wraps: 2-bit counter saturates at 3
    do_reset();
    for (int i = 0; i < 21; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("sat_sweeps_s", sweeps_s, 32'd3);
    check_val("sat_sweeps", sweeps, 32'd5);
    check_val("sat_wrap_s", wrap_s, 32'd1);

    // reset at idx 3 with wrap pending
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check_val("pend_idx", idx, 32'd3);
    check_val("pend_wrap", wrap, 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_val("midrst_wrap", wrap, 32'd0);
    check_val("midrst_sweeps", sweeps, 32'd0);

    // dir flip mid-run in circular mode: 0,1,2 then 1,0
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check_val("flip_idx", idx, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check_val("flip_idx2", idx, 32'd0);

    // switch into bounce at the top end while heading up
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    // random mix
    for (int i = 0; i < 150; i++) begin
      drive(($urandom_range(0, 24) != 0), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end

    if (exp_q.size() != 0) check_val("queue_left", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_digit_chaser
